// File: rtl/alu_cmd_driver.sv
// Drives single commands into a fixed-latency ALU. Each result, its flags and
// its opcode are queued in a response FIFO for a valid/ready consumer.
module alu_cmd_driver #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic [1:0]       i_cmd_oper,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [1:0]       o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [3:0]       i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_flag,
    output logic [1:0]       o_rsp_oper,
    output logic             o_busy,
    output logic [7:0]       o_err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]     LAT_L   = 3'(LAT);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] arg0_q, arg0_d;
    logic [WIDTH-1:0] arg1_q, arg1_d;
    logic [1:0]       oper_q, oper_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [WIDTH-1:0] mem_result_q [DEPTH];
    logic [3:0]       mem_flag_q   [DEPTH];
    logic [1:0]       mem_oper_q   [DEPTH];

    logic cmd_ready;
    logic accept;
    logic push;
    logic pop;

    // Command FSM. The opcode register that feeds the ALU also serves as the
    // latched opcode echoed into the response, since it holds until the next accept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arg0_d    = arg0_q;
        arg1_d    = arg1_q;
        oper_d    = oper_q;
        push      = 1'b0;
        cmd_ready = (state_q == IDLE) && (count_q < DEPTH_L);
        accept    = i_cmd_valid && cmd_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = LAT_L;
                    arg0_d  = i_cmd_a;
                    arg1_d  = i_cmd_b;
                    oper_d  = i_cmd_oper;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and occupancy update; a simultaneous push and pop cancel in the count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        pop       = (count_q != '0) && i_rsp_ready;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (push && i_alu_flag[0] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            oper_q    <= 2'b00;
            err_cnt_q <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arg0_q    <= arg0_d;
            arg1_q    <= arg1_d;
            oper_q    <= oper_d;
            err_cnt_q <= err_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: an emptied FIFO never exposes stale entries.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_result_q[wr_ptr_q] <= i_alu_result;
            mem_flag_q[wr_ptr_q]   <= i_alu_flag;
            mem_oper_q[wr_ptr_q]   <= oper_q;
        end
    end

    assign o_cmd_ready  = cmd_ready;
    assign o_alu_arg0   = arg0_q;
    assign o_alu_arg1   = arg1_q;
    assign o_alu_oper   = oper_q;
    assign o_rsp_valid  = (count_q != '0);
    assign o_rsp_result = mem_result_q[rd_ptr_q];
    assign o_rsp_flag   = mem_flag_q[rd_ptr_q];
    assign o_rsp_oper   = mem_oper_q[rd_ptr_q];
    assign o_busy       = (state_q != IDLE);
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver against a one-stage behavioural ALU model.
module tb_alu_cmd_driver;

    localparam int WIDTH = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [3:0] cmdA = 4'd0;
    logic [3:0] cmdB = 4'd0;
    logic [1:0] cmdOper = 2'd0;
    logic [3:0] aluArg0;
    logic [3:0] aluArg1;
    logic [1:0] aluOper;
    logic [3:0] aluResult = 4'd0;
    logic [3:0] aluFlag = 4'd0;
    logic       rspValid;
    logic       rspReady = 1'b0;
    logic [3:0] rspResult;
    logic [3:0] rspFlag;
    logic [1:0] rspOper;
    logic       busy;
    logic [7:0] errCnt;
    logic       forceErr = 1'b0;

    int testsRun  = 0;
    int failCount = 0;
    int cycle     = 0;

    logic [9:0] rspQ[$];

    logic [3:0] fullA [5] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic [3:0] fullB [5] = '{4'd5, 4'd9, 4'd3, 4'd2, 4'd8};
    logic [3:0] fullR [5] = '{4'd4, 4'd7, 4'd3, 4'd1, 4'd6};

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    alu_cmd_driver #(
        .WIDTH(WIDTH),
        .LAT  (LAT),
        .DEPTH(DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_a     (cmdA),
        .i_cmd_b     (cmdB),
        .i_cmd_oper  (cmdOper),
        .o_alu_arg0  (aluArg0),
        .o_alu_arg1  (aluArg1),
        .o_alu_oper  (aluOper),
        .i_alu_result(aluResult),
        .i_alu_flag  (aluFlag),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_result(rspResult),
        .o_rsp_flag  (rspFlag),
        .o_rsp_oper  (rspOper),
        .o_busy      (busy),
        .o_err_cnt   (errCnt)
    );

    function automatic logic [3:0] aluFn(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [3:0] n;
        logic       stop;
        n    = 4'd0;
        stop = 1'b0;
        case (op)
            2'b00: return b - a;
            2'b01: return ~(a & b);
            2'b10: begin
                for (int i = 3; i >= 0; i--) begin
                    if (!stop && a[i]) n = n + 4'd1;
                    else stop = 1'b1;
                end
                return n;
            end
            default: return 4'b0001 << a[1:0];
        endcase
    endfunction

    function automatic logic [3:0] aluFlags(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic err);
        logic [3:0] r;
        logic       ovf;
        r   = aluFn(op, a, b);
        ovf = (op == 2'b00) && (a[3] != b[3]) && (r[3] != b[3]);
        return {ovf, (!r[3] && (r != 4'd0)), r[3], err};
    endfunction

    // One register stage between the operand inputs and the result, i.e. LAT = 1.
    always @(posedge clk) begin
        aluResult <= aluFn(aluOper, aluArg0, aluArg1);
        aluFlag   <= aluFlags(aluOper, aluArg0, aluArg1, forceErr);
    end

    always @(negedge clk) begin
        if (rspValid === 1'b1 && rspReady === 1'b1)
            rspQ.push_back({rspOper, rspFlag, rspResult});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic popRsp(output logic [9:0] entry);
        if (rspQ.size() > 0) entry = rspQ.pop_front();
        else entry = 10'h3FF;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, output int acceptCycle);
        int guard;
        guard    = 0;
        cmdA     = a;
        cmdB     = b;
        cmdOper  = op;
        cmdValid = 1'b1;
        while (cmdReady !== 1'b1 && guard < 200) begin
            stepCycle();
            guard++;
        end
        if (cmdReady !== 1'b1) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            cmdValid    = 1'b0;
            acceptCycle = -1;
        end else begin
            stepCycle();
            acceptCycle = cycle;
            cmdValid    = 1'b0;
        end
    endtask

    initial begin
        int k;
        int k2;
        logic [9:0] entry;

        rst = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rstCmdReady", 32'(cmdReady), 32'd1);
        checkOutput("rstRspValid", 32'(rspValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstArg0", 32'(aluArg0), 32'd0);
        checkOutput("rstArg1", 32'(aluArg1), 32'd0);
        checkOutput("rstOper", 32'(aluOper), 32'd0);
        checkOutput("rstErrCnt", 32'(errCnt), 32'd0);
        rst = 1'b0;

        // Single subtract: 7 - 3 = 4, positive.
        rspReady = 1'b1;
        rspQ.delete();
        applyStimulus(4'd3, 4'd7, 2'b00, k);
        checkOutput("subArg0", 32'(aluArg0), 32'd3);
        checkOutput("subArg1", 32'(aluArg1), 32'd7);
        checkOutput("subBusy", 32'(busy), 32'd1);
        checkOutput("subReadyLow", 32'(cmdReady), 32'd0);
        stepCycle();
        checkOutput("subNoFallThrough", 32'(rspValid), 32'd0);
        stepCycle();
        checkOutput("subRspValid", 32'(rspValid), 32'd1);
        checkOutput("subResult", 32'(rspResult), 32'd4);
        checkOutput("subFlag", 32'(rspFlag), 32'b0100);
        checkOutput("subOper", 32'(rspOper), 32'd0);
        checkOutput("subReadyBack", 32'(cmdReady), 32'd1);
        stepCycle();
        checkOutput("subPopped", 32'(rspValid), 32'd0);

        // NAND then leading ones, issued back to back.
        rspQ.delete();
        applyStimulus(4'b1111, 4'b0001, 2'b01, k);
        applyStimulus(4'b1100, 4'b1111, 2'b10, k2);
        checkOutput("b2bSpacing", 32'(k2 - k), 32'd3);
        repeat (3) stepCycle();
        checkOutput("b2bCount", 32'(rspQ.size()), 32'd2);
        popRsp(entry);
        checkOutput("nandResult", 32'(entry[3:0]), 32'b1110);
        checkOutput("nandOper", 32'(entry[9:8]), 32'b01);
        popRsp(entry);
        checkOutput("loResult", 32'(entry[3:0]), 32'd2);
        checkOutput("loOper", 32'(entry[9:8]), 32'b10);

        // Fill the FIFO with the consumer stalled, then release one slot.
        rspReady = 1'b0;
        rspQ.delete();
        for (int i = 0; i < 4; i++) applyStimulus(fullA[i], fullB[i], 2'b00, k);
        stepCycle();
        stepCycle();
        checkOutput("fullReadyLow", 32'(cmdReady), 32'd0);
        checkOutput("fullRspValid", 32'(rspValid), 32'd1);
        checkOutput("fullHead", 32'(rspResult), 32'(fullR[0]));
        cmdA     = fullA[4];
        cmdB     = fullB[4];
        cmdOper  = 2'b00;
        cmdValid = 1'b1;
        repeat (3) stepCycle();
        checkOutput("fullStillBlocked", 32'(cmdReady), 32'd0);
        checkOutput("fullArgHeld", 32'(aluArg0), 32'(fullA[3]));
        rspReady = 1'b1;
        stepCycle();
        rspReady = 1'b0;
        checkOutput("fullReadyAfterPop", 32'(cmdReady), 32'd1);
        stepCycle();
        cmdValid = 1'b0;
        checkOutput("fifthAccepted", 32'(busy), 32'd1);
        checkOutput("fifthArg0", 32'(aluArg0), 32'(fullA[4]));
        rspReady = 1'b1;
        repeat (8) stepCycle();
        checkOutput("fullDrainCount", 32'(rspQ.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            popRsp(entry);
            checkOutput($sformatf("fullOrder%0d", i), 32'(entry[3:0]), 32'(fullR[i]));
        end

        // Error counter saturation.
        rspQ.delete();
        checkOutput("errCntStart", 32'(errCnt), 32'd0);
        forceErr = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            applyStimulus(4'(i), 4'(i + 3), 2'b00, k);
            stepCycle();
            stepCycle();
            if (i == 1 || i == 2 || i == 128 || i == 254 || i == 255 || i == 256 || i == 260)
                checkOutput($sformatf("errCnt%0d", i), 32'(errCnt), (i > 255) ? 32'd255 : 32'(i));
        end
        forceErr = 1'b0;
        stepCycle();

        // Reset while a command is in flight drops it.
        rspQ.delete();
        applyStimulus(4'd3, 4'd7, 2'b00, k);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstRspValid", 32'(rspValid), 32'd0);
        checkOutput("midRstReady", 32'(cmdReady), 32'd1);
        checkOutput("midRstArg0", 32'(aluArg0), 32'd0);
        checkOutput("midRstErrCnt", 32'(errCnt), 32'd0);
        applyStimulus(4'd5, 4'd6, 2'b00, k2);
        checkOutput("postRstAccept", 32'(k2 - k), 32'd2);
        repeat (4) stepCycle();
        checkOutput("postRstRspCount", 32'(rspQ.size()), 32'd1);
        popRsp(entry);
        checkOutput("postRstResult", 32'(entry[3:0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
